// File: rtl/lsu_mem_if.sv
// Load/store unit front end: checks alignment, drives a req/gnt/rvalid data bus
// with byte strobes and lane-replicated store data, and returns the aligned load word.
module lsu_mem_if #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lsu_start,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_funct3,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  output logic        lsu_misaligned,
  output logic        lsu_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  logic [1:0]       state;
  logic [1:0]       off;
  logic [CNT_W-1:0] cnt;
  logic             timeout_hit;

  function automatic logic illegal_req(input logic we, input logic [2:0] f3,
                                       input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    case (f3[1:0])
      2'b01:   bad = a[0];
      2'b10:   bad = (a != 2'b00) || f3[2];
      2'b11:   bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad || (we && f3[2]);
  endfunction

  function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] w);
    case (f3[1:0])
      2'b00:   return {4{w[7:0]}};
      2'b01:   return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] load_align(input logic [31:0] d, input logic [1:0] a);
    return d >> {a, 3'b000};
  endfunction

  // A response on the same edge as expiry is checked first, so it wins.
  assign timeout_hit = TIMEOUT_EN && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      off            <= 2'b00;
      cnt            <= '0;
      lsu_busy       <= 1'b0;
      lsu_done       <= 1'b0;
      lsu_rdata      <= 32'h0;
      lsu_misaligned <= 1'b0;
      lsu_err        <= 1'b0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= 32'h0;
      mem_wstrb      <= 4'b0000;
      mem_wdata      <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          lsu_done       <= 1'b0;
          lsu_misaligned <= 1'b0;
          lsu_err        <= 1'b0;
          if (lsu_start) begin
            lsu_busy <= 1'b1;
            if (illegal_req(lsu_we, lsu_funct3, lsu_addr[1:0])) begin
              state          <= DONE;
              lsu_done       <= 1'b1;
              lsu_misaligned <= 1'b1;
              lsu_rdata      <= 32'h0;
            end else begin
              state     <= REQ;
              off       <= lsu_addr[1:0];
              cnt       <= '0;
              mem_req   <= 1'b1;
              mem_we    <= lsu_we;
              mem_addr  <= {lsu_addr[31:2], 2'b00};
              mem_wstrb <= lsu_we ? store_strobe(lsu_funct3, lsu_addr[1:0]) : 4'b0000;
              mem_wdata <= store_lanes(lsu_funct3, lsu_wdata);
            end
          end
        end
        REQ: begin
          if (timeout_hit) begin
            state     <= DONE;
            mem_req   <= 1'b0;
            lsu_done  <= 1'b1;
            lsu_err   <= 1'b1;
            lsu_rdata <= 32'h0;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (mem_gnt) begin
              state   <= WAIT;
              mem_req <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state     <= DONE;
            lsu_done  <= 1'b1;
            lsu_rdata <= mem_we ? 32'h0 : load_align(mem_rdata, off);
          end else if (timeout_hit) begin
            state     <= DONE;
            lsu_done  <= 1'b1;
            lsu_err   <= 1'b1;
            lsu_rdata <= 32'h0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state          <= IDLE;
          lsu_busy       <= 1'b0;
          lsu_done       <= 1'b0;
          lsu_misaligned <= 1'b0;
          lsu_err        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Scoreboard bench for lsu_mem_if: a reference model predicts each completion,
// a monitor compares whenever lsu_done fires.
module tb_lsu_mem_if;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        lsu_start, lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_busy, lsu_done, lsu_misaligned, lsu_err;
  logic [31:0] lsu_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  lsu_mem_if #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .lsu_start(lsu_start), .lsu_we(lsu_we), .lsu_funct3(lsu_funct3),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_busy(lsu_busy), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .lsu_misaligned(lsu_misaligned), .lsu_err(lsu_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        err;
    int          done_cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (!reset && lsu_done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", {31'h0, lsu_done}, 32'h0);
      end else begin
        mon_e = sb_q.pop_front();
        check("rdata", lsu_rdata, mon_e.rdata);
        check("misaligned", {31'h0, lsu_misaligned}, {31'h0, mon_e.mis});
        check("err", {31'h0, lsu_err}, {31'h0, mon_e.err});
        check("done_cycle", cyc, mon_e.done_cyc);
      end
    end
  end

  // Reference model, from the access rules rather than the RTL structure.
  function automatic int size_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit ref_illegal(input bit we, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1;
    if (we && f3[2]) return 1;
    return (a % size_bytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] ref_strobe(input bit we, input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] s;
    int o;
    s = 4'b0000;
    o = int'(a % 4);
    if (we)
      for (int i = 0; i < 4; i++)
        if (i >= o && i < o + size_bytes(f3)) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % size_bytes(f3)) +: 8];
    return r;
  endfunction

  task automatic run_txn(input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int gd, input int rd,
                         input bit resp, input logic [31:0] rdat);
    bit   bad;
    bit   err;
    int   t;
    int   k;
    exp_t e;
    bad = ref_illegal(we, f3, a);
    err = !bad && (!resp || gd + rd + 2 > TO);
    t   = bad ? 0 : (err ? TO : gd + rd + 2);
    @(negedge clk);
    e.rdata    = (bad || err || we) ? 32'h0 : (rdat >> (8 * (a % 4)));
    e.mis      = bad;
    e.err      = err;
    e.done_cyc = cyc + 1 + t;
    sb_q.push_back(e);
    lsu_start  = 1'b1;
    lsu_we     = we;
    lsu_funct3 = f3;
    lsu_addr   = a;
    lsu_wdata  = wd;
    @(negedge clk);
    lsu_start = 1'b0;
    lsu_addr  = $urandom;
    lsu_wdata = $urandom;
    k = 0;
    while (lsu_busy && k < 40) begin
      if (!bad && k <= gd) begin
        check("mem_req", {31'h0, mem_req}, 32'h1);
        check("mem_we", {31'h0, mem_we}, {31'h0, we});
        check("mem_addr", mem_addr, {a[31:2], 2'b00});
        check("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, ref_strobe(we, f3, a)});
        if (we) check("mem_wdata", mem_wdata, ref_wdata(f3, wd));
      end else begin
        check("mem_req_idle", {31'h0, mem_req}, 32'h0);
      end
      mem_gnt    = !bad && (k == gd);
      mem_rvalid = (resp && !bad && k == gd + 1 + rd) || (!bad && k < gd && $urandom_range(0, 1) == 1);
      mem_rdata  = (k == gd + 1 + rd) ? rdat : $urandom;
      @(negedge clk);
      k++;
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    check("busy_cycles", k, t + 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'h0, lsu_busy}, 32'h0);
    check({tag, "_done"}, {31'h0, lsu_done}, 32'h0);
    check({tag, "_rdata"}, lsu_rdata, 32'h0);
    check({tag, "_mis"}, {31'h0, lsu_misaligned}, 32'h0);
    check({tag, "_err"}, {31'h0, lsu_err}, 32'h0);
    check({tag, "_req"}, {31'h0, mem_req}, 32'h0);
    check({tag, "_we"}, {31'h0, mem_we}, 32'h0);
    check({tag, "_addr"}, mem_addr, 32'h0);
    check({tag, "_wstrb"}, {28'h0, mem_wstrb}, 32'h0);
    check({tag, "_wdata"}, mem_wdata, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; lsu_start = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'b000;
    lsu_addr = 32'h0; lsu_wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // Directed cases from the access rules.
    run_txn(0, 3'b000, 32'h0000_0103, 32'h0, 0, 0, 1, 32'h80FF_1234);
    run_txn(1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 0, 0, 1, 32'h0);
    run_txn(0, 3'b010, 32'h0000_0101, 32'h0, 0, 0, 1, 32'h1111_1111);
    run_txn(0, 3'b001, 32'h0000_0003, 32'h0, 0, 0, 1, 32'h1111_1111);
    run_txn(1, 3'b100, 32'h0000_0100, 32'h0, 0, 0, 1, 32'h0);
    run_txn(1, 3'b000, 32'h0000_0201, 32'h0000_0055, 3, 1, 1, 32'h0);
    run_txn(0, 3'b101, 32'h0000_0302, 32'h0, 1, 5, 1, 32'hBEEF_7777);

    // Timeout with no response, then a stale response arriving in IDLE.
    run_txn(0, 3'b010, 32'h0000_0300, 32'h0, 1, 0, 0, 32'h0);
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("late_rvalid_done", {31'h0, lsu_done}, 32'h0);
    check("late_rvalid_busy", {31'h0, lsu_busy}, 32'h0);

    // Reset while waiting for a response abandons the access.
    @(negedge clk);
    lsu_start = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h0000_0040;
    @(negedge clk);
    lsu_start = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("midreset");
    run_txn(0, 3'b010, 32'h0000_0004, 32'h0, 0, 0, 1, 32'h1234_5678);

    // Randomized traffic, including occasional timeouts and illegal requests.
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 4),
              $urandom_range(0, 7) != 0, $urandom);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", sb_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
Load/store unit between the execute stage and the data-memory bus of the RISC-V core. It takes one load or store request at a time and checks alignment. It drives a request/grant/response bus with byte strobes and replicated store data. It stalls the pipeline while busy and returns the read word shifted so the addressed byte or halfword sits at bit 0, ready for the downstream load-data slicer, which handles sign/zero extension.

Parameters:
TIMEOUT_CYCLES, 255, cycles allowed in REQ+WAIT before aborting with error; 0 disables the timeout.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
lsu_start  in  1  request strobe; sampled only in IDLE
lsu_we  in  1  1 = store, 0 = load
lsu_funct3  in  3  RISC-V funct3 (size / sign), same encoding the slicer consumes
lsu_addr  in  32  byte address
lsu_wdata  in  32  store data, right-justified
lsu_busy  out  1  high whenever state != IDLE; pipeline stall
lsu_done  out  1  one-cycle completion pulse
lsu_rdata  out  32  load word shifted right by 8*addr[1:0]; 0 for stores and faults
lsu_misaligned  out  1  valid with lsu_done; alignment or illegal-size fault
lsu_err  out  1  valid with lsu_done; bus timeout
mem_req  out  1  bus request
mem_we  out  1  bus write
mem_addr  out  32  word address, {addr[31:2],2'b00}
mem_wstrb  out  4  byte enables; 0000 for loads
mem_wdata  out  32  lane-replicated store data
mem_gnt  in  1  request accepted at this edge
mem_rvalid  in  1  response (read data or write ack) at this edge
mem_rdata  in  32  read data, valid with mem_rvalid

Behaviour:
- Reset: state IDLE, all outputs 0, timeout counter 0. Reset mid-transaction abandons it; no done pulse. A late mem_rvalid arriving in IDLE is ignored.
- All outputs are registered. States are IDLE, REQ, WAIT, DONE.
- IDLE to REQ: lsu_start=1 and the request is legal. Latch addr, we, funct3 and wdata. mem_req=1 from the next cycle.
- IDLE to DONE (fault): lsu_start=1 and the request is illegal. lsu_misaligned=1 and no bus activity occurs.
- Illegal request: any of
  - half (f3[1:0]=01) with addr[0]=1;
  - word (f3=010) with addr[1:0]≠0;
  - f3 of 011, 110 or 111;
  - a store with f3[2]=1.
- REQ: mem_req, mem_we, mem_addr, mem_wstrb and mem_wdata stay constant until the edge where mem_gnt=1, then go to WAIT with mem_req=0. A mem_rvalid seen in REQ is ignored.
- WAIT to DONE: at the edge where mem_rvalid=1.
  - Load: lsu_rdata = mem_rdata >> (8*addr[1:0]).
  - Store: lsu_rdata = 0.
- DONE: lsu_done=1 for exactly one cycle, then IDLE. lsu_done, lsu_misaligned and lsu_err are cleared in IDLE. lsu_rdata holds until the next done.
- Minimum latency: start at edge N, mem_req high at N+1, gnt at N+1, rvalid at N+2, lsu_done high at N+3 (3 cycles). Fault: lsu_done at N+1.
- Store strobes, with off = addr[1:0]:
  - sb: 0001<<off, wdata = {4{wdata[7:0]}}.
  - sh: 0011<<off, wdata = {2{wdata[15:0]}}.
  - sw: 1111, wdata unchanged.
- Timeout: the counter increments each cycle in REQ/WAIT and clears on entering REQ. When it reaches TIMEOUT_CYCLES: mem_req drops, go to DONE with lsu_err=1 and lsu_rdata=0.
- Simultaneous events:
  - mem_rvalid and the timeout on the same edge: response wins, lsu_err=0.
  - lsu_start while busy: ignored; the upstream stage holds it under stall.

Test Plan:
- lb at addr 0x0000_0103, gnt at once, rvalid next cycle with mem_rdata=0x80FF_1234 -> mem_addr=0x100, mem_wstrb=0000, lsu_done at N+3, lsu_rdata=0x0000_0080, misaligned=0, err=0.
- sh at 0x0000_0102, wdata=0x0000_ABCD -> mem_we=1, mem_addr=0x100, mem_wstrb=1100, mem_wdata=0xABCD_ABCD; after ack, lsu_done with lsu_rdata=0.
- lw at 0x0000_0101; also lh at 0x0000_0003 and a store with f3=100 -> lsu_done and lsu_misaligned at N+1, mem_req never asserted, busy for 1 cycle.
- sb at 0x0000_0201 with wdata=0x55 and gnt delayed 3 cycles -> mem_req/addr/wstrb=0010/wdata=0x5555_5555 stable for all 4 REQ cycles; lsu_busy high throughout.
- TIMEOUT_CYCLES=8, load granted but no rvalid -> lsu_done with lsu_err=1 and lsu_rdata=0 after 8 REQ+WAIT cycles; a later rvalid is ignored and lsu_done stays 0.
- Reset asserted in WAIT -> next cycle all outputs 0 and busy=0; a new lw at 0x0000_0004 then completes normally with correct data.
